next_pc_sequencer: RTL and testbench

//  Drives the PC input of the Program_Counter register. Consumes PC_output
//  as pc_current and computes the next fetch address (sequential, branch,

---
 rtl/next_pc_sequencer_if.sv | 31 +++
 rtl/next_pc_sequencer.sv | 110 +++++++++++
 tb/tb_next_pc_sequencer.sv | 218 +++++++++++++++++++++
 3 files changed

// File: rtl/next_pc_sequencer_if.sv
// Fetch-path bundle between the control/ALU path (master) and the next-PC
// sequencer (slave). COUNT_W must match the sequencer's COUNT_W.
interface next_pc_sequencer_if #(
  parameter int COUNT_W = 16
);
  logic [31:0]        pc_current;
  logic               stall;
  logic               branch_taken;
  logic [31:0]        branch_imm;
  logic               jump;
  logic [25:0]        jump_target;
  logic               jr;
  logic [31:0]        jr_addr;
  logic [31:0]        pc_next;
  logic [31:0]        pc_plus4;
  logic               redirect_pending;
  logic               misaligned;
  logic [COUNT_W-1:0] fetch_count;

  modport master (
    output pc_current, stall, branch_taken, branch_imm,
           jump, jump_target, jr, jr_addr,
    input  pc_next, pc_plus4, redirect_pending, misaligned, fetch_count
  );

  modport slave (
    input  pc_current, stall, branch_taken, branch_imm,
           jump, jump_target, jr, jr_addr,
    output pc_next, pc_plus4, redirect_pending, misaligned, fetch_count
  );
endinterface

// File: rtl/next_pc_sequencer.sv
// Computes the next fetch address for Program_Counter. Holds the PC while
// stalled and replays a redirect that arrived during the stall.
module next_pc_sequencer #(
  parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
  parameter int          COUNT_W      = 16
) (
  input  logic                clk,
  input  logic                reset_n,
  next_pc_sequencer_if.slave  bus
);

  typedef enum logic [1:0] {
    BOOT = 2'd0,
    RUN  = 2'd1,
    HOLD = 2'd2,
    PEND = 2'd3
  } state_e;

  state_e             state_q, state_d;
  logic [31:0]        latch_q, latch_d;
  logic [COUNT_W-1:0] count_q, count_d;
  logic               mis_q, mis_d;

  logic [31:0] pc_plus4;
  logic [31:0] br_target;
  logic [31:0] j_target;
  logic [31:0] jr_target;
  logic [31:0] live_target;
  logic        live_req;
  logic [31:0] pc_next;

  // Candidate targets; all arithmetic wraps mod 2^32.
  always_comb begin
    pc_plus4  = bus.pc_current + 32'd4;
    br_target = pc_plus4 + {bus.branch_imm[29:0], 2'b00};
    j_target  = {pc_plus4[31:28], bus.jump_target, 2'b00};
    jr_target = {bus.jr_addr[31:2], 2'b00};
    live_req  = bus.jr | bus.jump | bus.branch_taken;
    if (bus.jr)        live_target = jr_target;
    else if (bus.jump) live_target = j_target;
    else               live_target = br_target;
  end

  // NOTE: every signal written here gets a default first, so no path can
  // leave one unassigned and infer a latch.
  always_comb begin
    state_d = state_q;
    latch_d = latch_q;
    count_d = count_q;
    pc_next = bus.pc_current;

    unique case (state_q)
      BOOT: begin
        pc_next = RESET_VECTOR;
        state_d = RUN;
      end
      RUN, HOLD: begin
        if (!bus.stall) begin
          pc_next = live_req ? live_target : pc_plus4;
          count_d = count_q + 1'b1;
          state_d = RUN;
        end else if (live_req) begin
          latch_d = live_target;
          state_d = PEND;
        end else begin
          state_d = HOLD;
        end
      end
      PEND: begin
        if (bus.stall) begin
          if (live_req) latch_d = live_target;
        end else begin
          // A live redirect in the release cycle beats the replayed one.
          pc_next = live_req ? live_target : latch_q;
          latch_d = '0;
          count_d = count_q + 1'b1;
          state_d = RUN;
        end
      end
      default: state_d = BOOT;
    endcase

    if (!reset_n) pc_next = RESET_VECTOR;
  end

  assign mis_d = bus.jr && (bus.jr_addr[1:0] != 2'b00) && (state_q != BOOT);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= BOOT;
      latch_q <= '0;
      count_q <= '0;
      mis_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      latch_q <= latch_d;
      count_q <= count_d;
      mis_q   <= mis_d;
    end
  end

  assign bus.pc_next          = pc_next;
  assign bus.pc_plus4         = pc_plus4;
  assign bus.redirect_pending = (state_q == PEND);
  assign bus.misaligned       = mis_q;
  assign bus.fetch_count      = count_q;

endmodule

// File: tb/tb_next_pc_sequencer.sv
// Directed vector table, a counter-wrap sequence and a randomized run checked
// against a rule-level model of the next-PC sequencer.
module tb_next_pc_sequencer;

  localparam int          CW = 4;
  localparam logic [31:0] RV = 32'h0000_0000;

  typedef struct {
    logic        rst_n;
    logic [31:0] pc;
    logic        st;
    logic        bt;
    logic [31:0] bi;
    logic        j;
    logic [25:0] jt;
    logic        r;
    logic [31:0] ra;
    logic        chk_regs;
    logic [31:0] e_pc;
    logic        e_pend;
    logic        e_mis;
    int          e_cnt;
  } vec_t;

  logic clk = 1'b0;
  logic reset_n;
  int   checks = 0;
  int   failures = 0;
  vec_t tbl[$];

  next_pc_sequencer_if #(.COUNT_W(CW)) bus_if ();

  next_pc_sequencer #(.RESET_VECTOR(RV), .COUNT_W(CW)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus_if)
  );

  always #5 clk = ~clk;

  // Rule-level reference model.
  bit          m_valid = 1'b0;
  bit          m_boot;
  logic [31:0] m_pend[$];
  bit          m_mis;
  int          m_cnt;
  logic [31:0] x_pc;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] target_of(input vec_t v, output bit live);
    logic [31:0] p4;
    p4   = v.pc + 32'd4;
    live = v.r || v.j || v.bt;
    if (v.r)      return v.ra & ~32'd3;
    else if (v.j) return (p4 & 32'hF000_0000) | (32'(v.jt) << 2);
    else          return p4 + v.bi * 32'd4;
  endfunction

  task automatic drive(input vec_t v);
    reset_n             = v.rst_n;
    bus_if.pc_current   = v.pc;
    bus_if.stall        = v.st;
    bus_if.branch_taken = v.bt;
    bus_if.branch_imm   = v.bi;
    bus_if.jump         = v.j;
    bus_if.jump_target  = v.jt;
    bus_if.jr           = v.r;
    bus_if.jr_addr      = v.ra;
  endtask

  function automatic logic [31:0] model_pc(input vec_t v);
    bit live;
    logic [31:0] t;
    t = target_of(v, live);
    if (!v.rst_n || m_boot) return RV;
    if (v.st)               return v.pc;
    if (live)               return t;
    if (m_pend.size() != 0) return m_pend[0];
    return v.pc + 32'd4;
  endfunction

  task automatic model_commit(input vec_t v);
    bit live;
    bit mis_n;
    logic [31:0] t;
    t = target_of(v, live);
    if (!v.rst_n) begin
      m_valid = 1'b1;
      m_boot  = 1'b1;
      m_pend.delete();
      m_mis   = 1'b0;
      m_cnt   = 0;
      return;
    end
    mis_n = v.r && (v.ra[1:0] != 2'b00) && !m_boot;
    if (m_boot) m_boot = 1'b0;
    else if (v.st) begin
      if (live) begin
        m_pend.delete();
        m_pend.push_back(t);
      end
    end else begin
      m_pend.delete();
      m_cnt = (m_cnt + 1) % (1 << CW);
    end
    m_mis = mis_n;
  endtask

  // One clock: drive, settle, compare (table or model), then take the edge.
  task automatic apply(input vec_t v, input bit use_model, input string tag);
    drive(v);
    #1;
    check({tag, " pc_plus4"}, bus_if.pc_plus4, v.pc + 32'd4);
    if (use_model) begin
      x_pc = model_pc(v);
      check({tag, " pc_next"}, bus_if.pc_next, x_pc);
      if (m_valid) begin
        check({tag, " pending"}, 32'(bus_if.redirect_pending), 32'(m_pend.size() != 0));
        check({tag, " misaligned"}, 32'(bus_if.misaligned), 32'(m_mis));
        check({tag, " fetch_count"}, 32'(bus_if.fetch_count), 32'(m_cnt));
      end
    end else begin
      check({tag, " pc_next"}, bus_if.pc_next, v.e_pc);
      if (v.chk_regs) begin
        check({tag, " pending"}, 32'(bus_if.redirect_pending), 32'(v.e_pend));
        check({tag, " misaligned"}, 32'(bus_if.misaligned), 32'(v.e_mis));
        check({tag, " fetch_count"}, 32'(bus_if.fetch_count), 32'(v.e_cnt));
      end
    end
    @(posedge clk);
    model_commit(v);
    #1;
  endtask

  task automatic add(input logic rst_n, input logic [31:0] pc, input logic st,
                     input logic bt, input logic [31:0] bi, input logic j,
                     input logic [25:0] jt, input logic r, input logic [31:0] ra,
                     input logic chk, input logic [31:0] e_pc, input logic e_pend,
                     input logic e_mis, input int e_cnt);
    vec_t v;
    v = '{rst_n, pc, st, bt, bi, j, jt, r, ra, chk, e_pc, e_pend, e_mis, e_cnt};
    tbl.push_back(v);
  endtask

  initial begin
    vec_t v;
    //   rst pc            st bt bi            j  jt            r  ra            chk e_pc          pnd mis cnt
    add(0, 32'h0000_0800, 0, 0, 32'h0,        0, 26'h0,        1, 32'h0000_0003, 0, RV,           0,  0,  0);
    add(0, 32'h0000_0800, 0, 0, 32'h0,        0, 26'h0,        1, 32'h0000_0003, 1, RV,           0,  0,  0);
    add(1, 32'h0000_0800, 0, 0, 32'h0,        0, 26'h0,        1, 32'h0000_0003, 1, RV,           0,  0,  0);
    add(1, 32'h0000_0000, 0, 0, 32'h0,        0, 26'h0,        0, 32'h0,         1, 32'h0000_0004, 0,  0,  0);
    add(1, 32'h0040_0010, 0, 1, 32'hFFFF_FFFE, 0, 26'h0,       0, 32'h0,         1, 32'h0040_000C, 0,  0,  1);
    add(1, 32'h0040_0010, 0, 1, 32'hFFFF_FFFE, 1, 26'h010_0010, 0, 32'h0,        1, 32'h0040_0040, 0,  0,  2);
    add(1, 32'h0040_0040, 1, 0, 32'h0,        0, 26'h0,        1, 32'h1000_0020, 1, 32'h0040_0040, 0,  0,  3);
    add(1, 32'h0040_0040, 1, 0, 32'h0,        0, 26'h0,        0, 32'h0,         1, 32'h0040_0040, 1,  0,  3);
    add(1, 32'h0040_0040, 1, 0, 32'h0,        0, 26'h0,        0, 32'h0,         1, 32'h0040_0040, 1,  0,  3);
    add(1, 32'h0040_0040, 0, 0, 32'h0,        0, 26'h0,        0, 32'h0,         1, 32'h1000_0020, 1,  0,  3);
    add(1, 32'h1000_0020, 0, 0, 32'h0,        0, 26'h0,        0, 32'h0,         1, 32'h1000_0024, 0,  0,  4);
    add(1, 32'h1000_0024, 1, 0, 32'h0,        0, 26'h0,        1, 32'h0000_0100, 1, 32'h1000_0024, 0,  0,  5);
    add(1, 32'h0000_0000, 0, 0, 32'h0,        1, 26'h40,       0, 32'h0,         1, 32'h0000_0100, 1,  0,  5);
    add(1, 32'h0000_0100, 1, 0, 32'h0,        0, 26'h0,        1, 32'h0000_0200, 1, 32'h0000_0100, 0,  0,  6);
    add(1, 32'h0000_0100, 1, 1, 32'h4,        0, 26'h0,        0, 32'h0,         1, 32'h0000_0100, 1,  0,  6);
    add(1, 32'h0000_0100, 0, 0, 32'h0,        1, 26'h40,       0, 32'h0,         1, 32'h0000_0100, 1,  0,  6);
    add(1, 32'h0000_0100, 1, 0, 32'h0,        0, 26'h0,        0, 32'h0,         1, 32'h0000_0100, 0,  0,  7);
    add(1, 32'h0000_0100, 0, 0, 32'h0,        0, 26'h0,        0, 32'h0,         1, 32'h0000_0104, 0,  0,  7);
    add(1, 32'h0000_0104, 1, 0, 32'h0,        0, 26'h0,        1, 32'h0000_0300, 1, 32'h0000_0104, 0,  0,  8);
    add(1, 32'h0000_0104, 1, 1, 32'h4,        0, 26'h0,        0, 32'h0,         1, 32'h0000_0104, 1,  0,  8);
    add(1, 32'h0000_0104, 0, 0, 32'h0,        0, 26'h0,        0, 32'h0,         1, 32'h0000_0118, 1,  0,  8);
    add(1, 32'h0000_0118, 0, 0, 32'h0,        0, 26'h0,        1, 32'h0000_0103, 1, 32'h0000_0100, 0,  0,  9);
    add(1, 32'h0000_0100, 0, 0, 32'h0,        0, 26'h0,        0, 32'h0,         1, 32'h0000_0104, 0,  1, 10);
    add(1, 32'h0000_0104, 1, 0, 32'h0,        0, 26'h0,        1, 32'h0000_0400, 1, 32'h0000_0104, 0,  0, 11);
    add(0, 32'h0000_0104, 0, 0, 32'h0,        0, 26'h0,        0, 32'h0,         1, RV,           1,  0, 11);
    add(1, 32'h0000_0104, 0, 0, 32'h0,        0, 26'h0,        0, 32'h0,         1, RV,           0,  0,  0);
    add(1, 32'h0000_0000, 0, 0, 32'h0,        0, 26'h0,        0, 32'h0,         1, 32'h0000_0004, 0,  0,  0);
    add(1, 32'h0000_0004, 1, 0, 32'h0,        0, 26'h0,        1, 32'h0000_0002, 1, 32'h0000_0004, 0,  0,  1);
    add(1, 32'h0000_0004, 0, 0, 32'h0,        0, 26'h0,        0, 32'h0,         1, 32'h0000_0000, 1,  1,  1);
    add(1, 32'h0000_0000, 0, 0, 32'h0,        0, 26'h0,        0, 32'h0,         1, 32'h0000_0004, 0,  0,  2);

    foreach (tbl[i]) apply(tbl[i], 1'b0, $sformatf("vec%0d", i));

    // Sixteen unstalled advances: fetch_count passes 15 -> 0.
    for (int i = 0; i < 16; i++) begin
      v = '{1'b1, 32'(i * 4), 1'b0, 1'b0, 32'h0, 1'b0, 26'h0, 1'b0, 32'h0,
            1'b1, 32'(i * 4 + 4), 1'b0, 1'b0, (3 + i) % 16};
      apply(v, 1'b0, $sformatf("wrap%0d", i));
    end

    // Randomized traffic against the model, starting from a fresh reset.
    for (int i = 0; i < 600; i++) begin
      v.rst_n = (i < 2) ? 1'b0 : ($urandom_range(0, 59) != 0);
      v.pc    = ($urandom_range(0, 3) == 0) ? $urandom() : ($urandom() & ~32'd3);
      v.st    = ($urandom_range(0, 9) < 4);
      v.bt    = ($urandom_range(0, 3) == 0);
      v.bi    = ($urandom_range(0, 1) != 0) ? $urandom() : 32'($signed(8'($urandom())));
      v.j     = ($urandom_range(0, 3) == 0);
      v.jt    = 26'($urandom());
      v.r     = ($urandom_range(0, 3) == 0);
      v.ra    = $urandom();
      v.chk_regs = 1'b1;
      v.e_pc  = '0;
      v.e_pend = 1'b0;
      v.e_mis = 1'b0;
      v.e_cnt = 0;
      apply(v, 1'b1, $sformatf("rnd%0d", i));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
